// File: rtl/bbox_accumulator.sv
// Per-label bounding-box table fed by a raster label stream. Applies labeler
// merges mid-frame, then drains boxes that meet an area threshold at end of frame.
module bbox_accumulator #(
  parameter int unsigned WIDTH_BITS  = 11,
  parameter int unsigned HEIGHT_BITS = 10,
  parameter int unsigned LABEL_WIDTH = 8,
  parameter int unsigned NUM_LABELS  = 64,
  parameter int unsigned COUNT_BITS  = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   pix_valid,
  input  logic [LABEL_WIDTH-1:0] pix_label,
  input  logic                   last_in_frame,
  input  logic                   merge_valid,
  input  logic [LABEL_WIDTH-1:0] merge_from,
  input  logic [LABEL_WIDTH-1:0] merge_into,
  input  logic [WIDTH_BITS-1:0]  width,
  input  logic [HEIGHT_BITS-1:0] height,
  input  logic [COUNT_BITS-1:0]  min_count,
  output logic                   busy,
  output logic                   bbox_valid,
  input  logic                   bbox_ready,
  output logic [LABEL_WIDTH-1:0] bbox_label,
  output logic [WIDTH_BITS-1:0]  bbox_min_x,
  output logic [HEIGHT_BITS-1:0] bbox_min_y,
  output logic [WIDTH_BITS-1:0]  bbox_max_x,
  output logic [HEIGHT_BITS-1:0] bbox_max_y,
  output logic [COUNT_BITS-1:0]  bbox_count,
  output logic                   frame_done,
  output logic                   overflow
);
  localparam int unsigned IDX_W = (NUM_LABELS > 1) ? $clog2(NUM_LABELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LABELS - 1);

  typedef struct packed {
    logic [WIDTH_BITS-1:0]  min_x;
    logic [WIDTH_BITS-1:0]  max_x;
    logic [HEIGHT_BITS-1:0] min_y;
    logic [HEIGHT_BITS-1:0] max_y;
    logic [COUNT_BITS-1:0]  count;
  } entry_t;

  typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

  // Union of two boxes; an entry with count 0 is empty and contributes nothing.
  function automatic entry_t unite(input entry_t a, input entry_t b);
    entry_t r;
    logic [COUNT_BITS:0] sum;
    sum     = {1'b0, a.count} + {1'b0, b.count};
    r.min_x = (a.min_x < b.min_x) ? a.min_x : b.min_x;
    r.max_x = (a.max_x > b.max_x) ? a.max_x : b.max_x;
    r.min_y = (a.min_y < b.min_y) ? a.min_y : b.min_y;
    r.max_y = (a.max_y > b.max_y) ? a.max_y : b.max_y;
    r.count = sum[COUNT_BITS] ? '1 : sum[COUNT_BITS-1:0];
    if (a.count == '0) r = b;
    else if (b.count == '0) r = a;
    return r;
  endfunction

  function automatic logic in_range(input logic [LABEL_WIDTH-1:0] l);
    return 32'(l) < NUM_LABELS;
  endfunction

  state_t                 state, state_next;
  entry_t                 tbl [NUM_LABELS];
  logic [WIDTH_BITS-1:0]  x;
  logic [HEIGHT_BITS-1:0] y;
  logic [IDX_W-1:0]       ptr;
  logic                   scan_done;
  logic [COUNT_BITS-1:0]  thr;

  logic             pix_ok, pix_oor, mrg_act, mrg_oor;
  logic [IDX_W-1:0] from_i, into_i, pix_i;
  entry_t           merged, base, pix_e, updated, scan_e;
  logic             go_drain, accept, scan_step, emit, finish;

  assign busy = (state == DRAIN);

  // Accumulate datapath: merge applied first, pixel folded on top of the result.
  always_comb begin
    pix_ok  = pix_valid && (pix_label != '0) && in_range(pix_label);
    pix_oor = pix_valid && !in_range(pix_label);
    mrg_oor = merge_valid && (!in_range(merge_from) || !in_range(merge_into));
    mrg_act = merge_valid && !mrg_oor && (merge_from != '0) && (merge_into != '0)
              && (merge_from != merge_into);
    from_i  = IDX_W'(merge_from);
    into_i  = IDX_W'(merge_into);
    pix_i   = (mrg_act && (pix_label == merge_from)) ? into_i : IDX_W'(pix_label);
    merged  = unite(tbl[into_i], tbl[from_i]);
    base    = (mrg_act && (pix_i == into_i)) ? merged : tbl[pix_i];
    pix_e   = '{min_x: x, max_x: x, min_y: y, max_y: y, count: COUNT_BITS'(1)};
    updated = unite(base, pix_e);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (go_drain) state_next = DRAIN;
      DRAIN:   if (finish) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  // Drain control: a pending box stalls the scan until it is accepted.
  always_comb begin
    go_drain  = 1'b0;
    accept    = 1'b0;
    scan_step = 1'b0;
    emit      = 1'b0;
    finish    = 1'b0;
    scan_e    = tbl[ptr];
    if (enable) begin
      if (state == ACCUM) begin
        go_drain = pix_valid && last_in_frame;
      end else begin
        accept    = bbox_valid && bbox_ready;
        scan_step = !bbox_valid && !scan_done;
        emit      = scan_step && (scan_e.count != '0) && (scan_e.count >= thr);
        finish    = (accept && scan_done) || (!bbox_valid && scan_done)
                    || (scan_step && (ptr == LAST_IDX) && !emit);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LABELS; i++) tbl[i].count <= '0;
      x          <= '0;
      y          <= '0;
      ptr        <= IDX_W'(1);
      scan_done  <= 1'b0;
      thr        <= '0;
      bbox_valid <= 1'b0;
      bbox_label <= '0;
      bbox_min_x <= '0;
      bbox_min_y <= '0;
      bbox_max_x <= '0;
      bbox_max_y <= '0;
      bbox_count <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else if (enable) begin
      frame_done <= 1'b0;
      if (state == ACCUM) begin
        if (pix_oor || mrg_oor) overflow <= 1'b1;
        if (mrg_act) begin
          tbl[from_i].count <= '0;
          tbl[into_i]       <= merged;
        end
        if (pix_ok) tbl[pix_i] <= updated;
        if (pix_valid) begin
          if (last_in_frame) begin
            x <= '0;
            y <= '0;
          end else if (x == width - WIDTH_BITS'(1)) begin
            x <= '0;
            y <= (y == height - HEIGHT_BITS'(1)) ? '0 : y + HEIGHT_BITS'(1);
          end else begin
            x <= x + WIDTH_BITS'(1);
          end
        end
        if (go_drain) begin
          thr       <= min_count;
          ptr       <= IDX_W'(1);
          scan_done <= 1'b0;
        end
      end else begin
        if (accept) bbox_valid <= 1'b0;
        if (scan_step) begin
          tbl[ptr].count <= '0;
          if (emit) begin
            bbox_valid <= 1'b1;
            bbox_label <= LABEL_WIDTH'(ptr);
            bbox_min_x <= scan_e.min_x;
            bbox_min_y <= scan_e.min_y;
            bbox_max_x <= scan_e.max_x;
            bbox_max_y <= scan_e.max_y;
            bbox_count <= scan_e.count;
          end
          if (ptr == LAST_IDX) scan_done <= 1'b1;
          else                 ptr <= ptr + IDX_W'(1);
        end
        if (finish) begin
          frame_done <= 1'b1;
          overflow   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bbox_accumulator.sv
// Bench for bbox_accumulator: raster-level reference model, per-cycle output
// monitor, directed frames with literal expectations and randomized frames.
module tb_bbox_accumulator;
  localparam int WB = 11;
  localparam int HB = 10;
  localparam int LW = 8;
  localparam int NL = 64;
  localparam int CB = 21;
  localparam int CMAX = (1 << CB) - 1;
  localparam int CATW = LW + 2 * WB + 2 * HB + CB;

  logic          clk = 1'b0;
  logic          rst, enable, pix_valid, last_in_frame, merge_valid, bbox_ready;
  logic [LW-1:0] pix_label, merge_from, merge_into;
  logic [WB-1:0] width;
  logic [HB-1:0] height;
  logic [CB-1:0] min_count;
  logic          busy, bbox_valid, frame_done, overflow;
  logic [LW-1:0] bbox_label;
  logic [WB-1:0] bbox_min_x, bbox_max_x;
  logic [HB-1:0] bbox_min_y, bbox_max_y;
  logic [CB-1:0] bbox_count;

  bbox_accumulator dut (
    .clk(clk), .rst(rst), .enable(enable), .pix_valid(pix_valid), .pix_label(pix_label),
    .last_in_frame(last_in_frame), .merge_valid(merge_valid), .merge_from(merge_from),
    .merge_into(merge_into), .width(width), .height(height), .min_count(min_count),
    .busy(busy), .bbox_valid(bbox_valid), .bbox_ready(bbox_ready), .bbox_label(bbox_label),
    .bbox_min_x(bbox_min_x), .bbox_min_y(bbox_min_y), .bbox_max_x(bbox_max_x),
    .bbox_max_y(bbox_max_y), .bbox_count(bbox_count), .frame_done(frame_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { int lab; int x0; int y0; int x1; int y1; int cnt; } box_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_x0[NL], m_y0[NL], m_x1[NL], m_y1[NL], m_cnt[NL];
  bit   m_ovf, exp_ovf;
  int   m_pos, m_w, m_h;
  box_t exp_q[$];
  box_t got_q[$];
  int   fmap[128], fmf[128], fmi[128];
  int   stall_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: table of boxes indexed by label, updated per raster pixel.
  task automatic m_clear();
    for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    m_pos = 0;
    m_ovf = 1'b0;
  endtask

  task automatic m_union(input int d, input int s);
    if (m_cnt[s] == 0) return;
    if (m_cnt[d] == 0) begin
      m_x0[d] = m_x0[s]; m_x1[d] = m_x1[s]; m_y0[d] = m_y0[s]; m_y1[d] = m_y1[s];
      m_cnt[d] = m_cnt[s];
    end else begin
      if (m_x0[s] < m_x0[d]) m_x0[d] = m_x0[s];
      if (m_x1[s] > m_x1[d]) m_x1[d] = m_x1[s];
      if (m_y0[s] < m_y0[d]) m_y0[d] = m_y0[s];
      if (m_y1[s] > m_y1[d]) m_y1[d] = m_y1[s];
      m_cnt[d] = (m_cnt[d] + m_cnt[s] > CMAX) ? CMAX : m_cnt[d] + m_cnt[s];
    end
  endtask

  task automatic m_step(input bit pv, input int lab, input bit last, input bit mv,
                        input int mf, input int mi, input int thr);
    bit   redir;
    int   l, px, py;
    box_t b;
    redir = 1'b0;
    if (mv) begin
      if (mf >= NL || mi >= NL) m_ovf = 1'b1;
      else if (mf != 0 && mi != 0 && mf != mi) begin
        m_union(mi, mf);
        m_cnt[mf] = 0;
        redir = 1'b1;
      end
    end
    if (pv) begin
      l  = (redir && lab == mf) ? mi : lab;
      px = m_pos % m_w;
      py = (m_pos / m_w) % m_h;
      if (l >= NL) m_ovf = 1'b1;
      else if (l != 0) begin
        if (m_cnt[l] == 0) begin
          m_x0[l] = px; m_x1[l] = px; m_y0[l] = py; m_y1[l] = py; m_cnt[l] = 1;
        end else begin
          if (px < m_x0[l]) m_x0[l] = px;
          if (px > m_x1[l]) m_x1[l] = px;
          if (py < m_y0[l]) m_y0[l] = py;
          if (py > m_y1[l]) m_y1[l] = py;
          if (m_cnt[l] < CMAX) m_cnt[l]++;
        end
      end
      m_pos++;
      if (last) begin
        for (int i = 1; i < NL; i++) begin
          if (m_cnt[i] != 0 && m_cnt[i] >= thr) begin
            b.lab = i; b.x0 = m_x0[i]; b.y0 = m_y0[i];
            b.x1 = m_x1[i]; b.y1 = m_y1[i]; b.cnt = m_cnt[i];
            exp_q.push_back(b);
          end
        end
        exp_ovf = m_ovf;
        m_clear();
      end
    end
  endtask

  // Output monitor: hold stability while stalled, accepted boxes vs. model order.
  bit             prev_pending = 1'b0;
  logic [CATW-1:0] prev_cat;
  always @(negedge clk) begin
    logic [CATW-1:0] cat;
    box_t g, e;
    cat = {bbox_label, bbox_min_x, bbox_min_y, bbox_max_x, bbox_max_y, bbox_count};
    if (rst) begin
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) begin
        chk("hold_valid", bbox_valid, 1);
        chk("hold_fields", 64'(cat === prev_cat), 1);
      end
      if (bbox_valid && bbox_ready && enable) begin
        g.lab = int'(bbox_label); g.x0 = int'(bbox_min_x); g.y0 = int'(bbox_min_y);
        g.x1 = int'(bbox_max_x); g.y1 = int'(bbox_max_y); g.cnt = int'(bbox_count);
        got_q.push_back(g);
        if (exp_q.size() == 0) begin
          chk("unexpected_box_label", g.lab, 0);
        end else begin
          e = exp_q.pop_front();
          chk("box_label", g.lab, e.lab);
          chk("box_min_x", g.x0, e.x0);
          chk("box_min_y", g.y0, e.y0);
          chk("box_max_x", g.x1, e.x1);
          chk("box_max_y", g.y1, e.y1);
          chk("box_count", g.cnt, e.cnt);
        end
      end
      prev_pending = bbox_valid && !(bbox_ready && enable);
      prev_cat     = cat;
    end
  end

  task automatic drive(input bit en, input bit pv, input int lab, input bit last,
                       input bit mv, input int mf, input int mi);
    enable = en; pix_valid = pv; pix_label = LW'(lab); last_in_frame = last;
    merge_valid = mv; merge_from = LW'(mf); merge_into = LW'(mi);
    if (en) m_step(pv, lab, last, mv, mf, mi, int'(min_count));
    @(posedge clk); #1;
    pix_valid = 1'b0; merge_valid = 1'b0; last_in_frame = 1'b0; enable = 1'b1;
  endtask

  task automatic clear_map();
    for (int p = 0; p < 128; p++) begin fmap[p] = 0; fmf[p] = 0; fmi[p] = 0; end
  endtask

  task automatic send_frame(input int w, input int h, input int thr, input bit noisy);
    width = WB'(w); height = HB'(h); min_count = CB'(thr); m_w = w; m_h = h;
    for (int p = 0; p < w * h; p++) begin
      if (noisy && ($urandom % 8) == 0) drive(0, 1, int'($urandom % NL), 0, 1, 1, 2);
      drive(1, 1, fmap[p], p == w * h - 1, fmf[p] != 0, fmf[p], fmi[p]);
    end
    chk("busy_after_last", busy, 1);
    chk("overflow_in_drain", overflow, 64'(exp_ovf));
  endtask

  // mode 0: always ready; 1: random ready/enable/min_count; 2: 10-cycle stall on first box
  task automatic run_drain(input int mode);
    bit done;
    done = 1'b0;
    stall_seen = 0;
    for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
      case (mode)
        0: bbox_ready = 1'b1;
        1: begin
          bbox_ready = 1'($urandom % 2);
          enable     = ($urandom % 4) != 0;
          min_count  = CB'($urandom % 8);
        end
        default: begin
          if (bbox_valid && stall_seen < 10) begin bbox_ready = 1'b0; stall_seen++; end
          else bbox_ready = 1'b1;
        end
      endcase
      @(posedge clk); #1;
      if (frame_done) done = 1'b1;
    end
    enable = 1'b1;
    bbox_ready = 1'b0;
    chk("drain_done", 64'(done), 1);
    chk("busy_after_done", busy, 0);
    chk("overflow_after_done", overflow, 0);
    chk("expected_boxes_left", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    chk("frame_done_pulse_width", frame_done, 0);
  endtask

  task automatic chk_box(input int idx, input int lab, input int x0, input int y0,
                         input int x1, input int y1, input int cnt);
    if (got_q.size() > idx) begin
      chk("lit_label", got_q[idx].lab, lab);
      chk("lit_min_x", got_q[idx].x0, x0);
      chk("lit_min_y", got_q[idx].y0, y0);
      chk("lit_max_x", got_q[idx].x1, x1);
      chk("lit_max_y", got_q[idx].y1, y1);
      chk("lit_count", got_q[idx].cnt, cnt);
    end else begin
      chk("lit_box_present", got_q.size(), idx + 1);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h, r;
    rst = 1'b1; enable = 1'b1; pix_valid = 1'b0; last_in_frame = 1'b0; merge_valid = 1'b0;
    pix_label = '0; merge_from = '0; merge_into = '0; bbox_ready = 1'b0;
    width = WB'(8); height = HB'(4); min_count = '0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_bbox_valid", bbox_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_bbox_label", bbox_label, 0);
    chk("reset_bbox_count", bbox_count, 0);
    rst = 1'b0;

    // single label, three pixels
    clear_map(); got_q.delete();
    fmap[10] = 3; fmap[21] = 3; fmap[27] = 3;
    send_frame(8, 4, 1, 0); run_drain(0);
    chk("t1_boxes", got_q.size(), 1); chk_box(0, 3, 2, 1, 5, 3, 3);

    // merge 2 into 1 on the last pixel
    clear_map(); got_q.delete();
    fmap[0] = 1; fmap[30] = 2; fmf[31] = 2; fmi[31] = 1;
    send_frame(8, 4, 1, 0); run_drain(0);
    chk("t2_boxes", got_q.size(), 1); chk_box(0, 1, 0, 0, 6, 3, 2);

    // pixel of merge_from label in the merge cycle is redirected
    clear_map(); got_q.delete();
    fmap[3] = 5; fmap[9] = 4; fmf[9] = 4; fmi[9] = 5;
    send_frame(8, 4, 1, 0); run_drain(0);
    chk("t3_boxes", got_q.size(), 1); chk_box(0, 5, 1, 0, 3, 1, 2);

    // area threshold
    clear_map(); got_q.delete();
    fmap[0] = 1; for (int p = 1; p <= 5; p++) fmap[p] = 2;
    send_frame(8, 4, 3, 0); run_drain(0);
    chk("t4_boxes", got_q.size(), 1); chk_box(0, 2, 1, 0, 5, 0, 5);

    // back-pressure on the first box
    clear_map(); got_q.delete();
    fmap[2] = 2; fmap[10] = 6;
    send_frame(8, 4, 1, 0); run_drain(2);
    chk("t5_stall_cycles", stall_seen, 10);
    chk("t5_boxes", got_q.size(), 2);
    chk_box(0, 2, 2, 0, 2, 0, 1); chk_box(1, 6, 2, 1, 2, 1, 1);

    // out-of-range label
    clear_map(); got_q.delete();
    fmap[4] = NL;
    send_frame(8, 4, 1, 0);
    chk("t6_overflow_set", overflow, 1);
    run_drain(0);
    chk("t6_boxes", got_q.size(), 0);

    // highest label with min_count 0: empty entries still skipped
    clear_map(); got_q.delete();
    fmap[0] = NL - 1;
    send_frame(8, 4, 0, 0); run_drain(0);
    chk("t7_boxes", got_q.size(), 1); chk_box(0, NL - 1, 0, 0, 0, 0, 1);

    // reset while a box is pending
    clear_map(); got_q.delete();
    fmap[0] = 1; fmap[1] = 2;
    send_frame(8, 4, 1, 0);
    bbox_ready = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bbox_valid) break;
      @(posedge clk); #1;
    end
    chk("t8_valid_before_rst", bbox_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t8_valid_after_rst", bbox_valid, 0);
    chk("t8_busy_after_rst", busy, 0);
    chk("t8_frame_done_after_rst", frame_done, 0);
    m_clear(); exp_q.delete(); got_q.delete();
    clear_map();
    fmap[5] = 7;
    send_frame(8, 4, 1, 0); run_drain(0);
    chk("t8_boxes", got_q.size(), 1); chk_box(0, 7, 5, 0, 5, 0, 1);

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      clear_map();
      w = 3 + int'($urandom % 10);
      h = 2 + int'($urandom % 5);
      for (int p = 0; p < w * h; p++) begin
        r = int'($urandom % 100);
        if (r < 50)      fmap[p] = 0;
        else if (r < 92) fmap[p] = 1 + int'($urandom % 8);
        else if (r < 97) fmap[p] = 60 + int'($urandom % 4);
        else             fmap[p] = NL + int'($urandom % 2);
        if (($urandom % 10) == 0) begin
          fmf[p] = (($urandom % 12) == 0) ? NL : 1 + int'($urandom % 9);
          fmi[p] = (($urandom % 8) == 0) ? NL - 1 : 1 + int'($urandom % 9);
        end
      end
      send_frame(w, h, int'($urandom % 4), 1);
      run_drain(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bbox_accumulator.md
Name: bbox_accumulator

Overview:
- Parametrised successor to the single-box bounding-box stage in the motion pipeline.
- Consumes a raster stream of component labels from the labeling stage (label 0 = background) and keeps a per-label table: min/max x, min/max y and pixel count.
- Applies label merges issued by the labeler mid-frame.
- At end of frame, drains every box whose count passes a programmable area threshold over a valid/ready output.

Parameters:
WIDTH_BITS, 11, x coordinate / frame width width
HEIGHT_BITS, 10, y coordinate / frame height width
LABEL_WIDTH, 8, label field width
NUM_LABELS, 64, table entries; legal labels 1..NUM_LABELS-1
COUNT_BITS, 21, pixel-count width, saturating

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  global enable; 0 freezes all state, outputs held
pix_valid  in  1  input pixel strobe
pix_label  in  LABEL_WIDTH  component label of pixel
last_in_frame  in  1  qualifies final pixel of frame (with pix_valid)
merge_valid  in  1  merge request strobe
merge_from  in  LABEL_WIDTH  label absorbed
merge_into  in  LABEL_WIDTH  label surviving
width  in  WIDTH_BITS  frame width, static per frame
height  in  HEIGHT_BITS  frame height, static per frame
min_count  in  COUNT_BITS  drain threshold, sampled at drain start
busy  out  1  high in DRAIN; inputs ignored
bbox_valid  out  1  output box valid
bbox_ready  in  1  downstream accept
bbox_label  out  LABEL_WIDTH  label of box
bbox_min_x  out  WIDTH_BITS  box left
bbox_min_y  out  HEIGHT_BITS  box top
bbox_max_x  out  WIDTH_BITS  box right
bbox_max_y  out  HEIGHT_BITS  box bottom
bbox_count  out  COUNT_BITS  pixel count
frame_done  out  1  one-cycle pulse after last box of frame
overflow  out  1  sticky; out-of-range label or merge this frame

Behaviour:
- Reset: all outputs 0; state ACCUM; x=y=0; all table entries empty (count=0); overflow=0.
- States: ACCUM, DRAIN.

ACCUM state:
- Internal x/y counters advance on each pix_valid.
- x wraps at width-1 and increments y; y wraps at height-1.
- pix_label in 1..NUM_LABELS-1 updates its entry next cycle:
  - empty entry: set min=max=(x,y), count=1
  - otherwise: min/max widen, count+1 saturating at all-ones.
- Label 0: no table update; counters still advance.
- Label >= NUM_LABELS: pixel dropped, overflow set.
- merge_valid with both labels in range and from!=into:
  - into entry becomes the union box; counts add, saturating.
  - from entry is cleared.
  - If from is empty: no-op. If into is empty: copy from's entry.
  - from==into: no-op. Out-of-range label: dropped, overflow set.
- Merge and pixel in the same cycle:
  - Merge is applied first.
  - A pixel labeled merge_from is redirected to merge_into.
  - A pixel labeled merge_into is folded into the union in the same update.
- pix_valid && last_in_frame:
  - That pixel is applied; x/y reset to 0.
  - DRAIN is entered next cycle; min_count is latched.

DRAIN state:
- busy=1; pix_valid and merge_valid are ignored. The upstream must not send pixels or merges while busy is high.
- Scan pointer runs 1..NUM_LABELS-1, one entry per cycle when not stalled.
- Entry with count>=min_count and count!=0: load output registers, assert bbox_valid. Hold all fields stable until bbox_valid && bbox_ready. The pointer stalls meanwhile.
- Each scanned entry is cleared after its decision (emitted or skipped).
- After the last entry is scanned and any pending box is accepted:
  - frame_done pulses 1 cycle
  - overflow clears in the same cycle
  - return to ACCUM.
- min_count=0 still skips empty entries.
- Boxes are emitted in ascending label order.

Control:
- enable=0 stalls counters, table, scan and handshake; bbox_valid is held.
- rst mid-DRAIN: table cleared, bbox_valid dropped immediately, no frame_done pulse.

Test Plan:
- width=8,height=4; label 3 at (2,1),(5,2),(3,3), last on (7,3), min_count=1, bbox_ready=1 -> one box: label 3, min (2,1), max (5,3), count 3; frame_done 1 cycle after accept; busy deasserts.
- Labels 1 at (0,0) and 2 at (6,3); merge_valid from=2 into=1 -> single box label 1, min (0,0), max (6,3), count 2; label 2 not emitted.
- Pixel label 4 at (1,1) in the same cycle as merge from=4 into=5, with entry 5 at (3,0) -> box label 5, min (1,0), max (3,1), count 2.
- Labels 1 (count 1) and 2 (count 5), min_count=3 -> only label 2 emitted.
- Label 2 box with bbox_ready low 10 cycles -> bbox_valid and all fields stable for 10 cycles; accepted on the first ready cycle; next box follows.
- pix_label=NUM_LABELS -> overflow=1, no box; overflow=0 after frame_done. Separately, rst asserted mid-DRAIN -> bbox_valid=0 next cycle, next frame starts with an empty table.
